mem_port_arbiter: RTL and testbench

//  Shares the single-port data/stack RAM between instruction fetch (IF) and the

---
 rtl/mem_port_arbiter_pkg.sv | 8 +
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the RAM port arbiter
// Purpose: FSM state and port-owner encodings used by mem_port_arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} e_arb_state;
    typedef enum logic {OWN_IF, OWN_DATA} e_arb_owner;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter between fetch and data ports
// Purpose: grants one access at a time to the instruction-fetch or data port,
//   issues it to the RAM, and returns a one-cycle ack with read data after RAM_LAT.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request and address (held until if_ack)
//   if_rdata/if_ack/if_stall      fetch response and freeze indication
//   d_req/d_we/d_addr/d_wdata     data request (held until d_ack)
//   d_rdata/d_ack/d_stall         data response and freeze indication
//   ram_addr/ram_we/ram_wdata     RAM command, issued in the grant cycle
//   ram_rdata                     RAM read data, valid RAM_LAT cycles after address
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RAM_LAT    = 1,
    parameter int MAX_STARVE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int LAT_W = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);
    localparam int ST_W  = (MAX_STARVE < 2) ? 1 : $clog2(MAX_STARVE + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(RAM_LAT - 1);
    localparam logic [ST_W-1:0]  STARVE_MAX = ST_W'(MAX_STARVE);

    e_arb_state        state_q, state_d;
    e_arb_owner        owner_q, owner_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [ST_W-1:0]   starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant_if;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lat_cnt_d  = lat_cnt_q;
        starve_d   = starve_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        grant_if   = 1'b0;
        ram_addr   = '0;
        ram_we     = 1'b0;
        ram_wdata  = '0;
        if_ack     = 1'b0;
        d_ack      = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (if_req || d_req) begin
                    // Data normally wins; fetch is forced through once it has lost MAX_STARVE times.
                    grant_if  = if_req && (!d_req || starve_q == STARVE_MAX);
                    addr_d    = grant_if ? if_addr : d_addr;
                    we_d      = !grant_if && d_we;
                    wdata_d   = grant_if ? '0 : d_wdata;
                    owner_d   = grant_if ? OWN_IF : OWN_DATA;
                    ram_addr  = addr_d;
                    ram_we    = we_d;
                    ram_wdata = wdata_d;
                    state_d   = ARB_BUSY;
                    lat_cnt_d = LAT_LOAD;
                    if (!if_req || grant_if) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else begin
                    starve_d = '0;
                end
            end
            ARB_BUSY: begin
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                if (!if_req) begin
                    starve_d = '0;
                end
                if (lat_cnt_q == '0) begin
                    state_d = ARB_IDLE;
                    if (owner_q == OWN_IF) begin
                        if_ack     = 1'b1;
                        if_rdata_d = ram_rdata;
                    end else begin
                        d_ack = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = ram_rdata;
                        end
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Reset abandons any in-flight access and keeps the RAM quiet that cycle.
        if (rst) begin
            ram_addr  = '0;
            ram_we    = 1'b0;
            ram_wdata = '0;
            if_ack    = 1'b0;
            d_ack     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_DATA;
            lat_cnt_q  <= '0;
            starve_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lat_cnt_q  <= lat_cnt_d;
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Read data is forwarded in the ack cycle and held afterwards.
    assign if_rdata = if_ack ? ram_rdata : if_rdata_q;
    assign d_rdata  = (d_ack && !we_q) ? ram_rdata : d_rdata_q;
    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter (RAM_LAT 1 and 3)
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    // RAM_LAT = 1 instance
    logic       if_req = 1'b0, if_ack, if_stall;
    logic [7:0] if_addr = '0, if_rdata;
    logic       d_req = 1'b0, d_we = 1'b0, d_ack, d_stall;
    logic [7:0] d_addr = '0, d_wdata = '0, d_rdata;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       ram_we;

    // RAM_LAT = 3 instance
    logic       if3_req = 1'b0, if3_ack, if3_stall;
    logic [7:0] if3_addr = '0, if3_rdata;
    logic       d3_req = 1'b0, d3_we = 1'b0, d3_ack, d3_stall;
    logic [7:0] d3_addr = '0, d3_wdata = '0, d3_rdata;
    logic [7:0] ram3_addr, ram3_wdata, ram3_rdata;
    logic       ram3_we;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_LAT(1), .MAX_STARVE(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_LAT(3), .MAX_STARVE(2)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(if3_req), .if_addr(if3_addr), .if_rdata(if3_rdata), .if_ack(if3_ack), .if_stall(if3_stall),
        .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
        .d_rdata(d3_rdata), .d_ack(d3_ack), .d_stall(d3_stall),
        .ram_addr(ram3_addr), .ram_we(ram3_we), .ram_wdata(ram3_wdata), .ram_rdata(ram3_rdata)
    );

    // RAM models: read data appears RAM_LAT cycles after the address is presented.
    logic [7:0] mem  [256];
    logic [7:0] mem3 [256];
    logic [7:0] pipe1;
    logic [7:0] pipe3 [3];

    always @(posedge clk) begin
        pipe1 <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
        pipe3[0] <= mem3[ram3_addr];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
        if (ram3_we) mem3[ram3_addr] <= ram3_wdata;
    end
    assign ram_rdata  = pipe1;
    assign ram3_rdata = pipe3[2];

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'h00;
            mem3[i] = 8'h00;
        end
        mem[8'h10]  = 8'hC3;
        mem[8'h20]  = 8'h77;
        mem3[8'h30] = 8'hA5;
        mem3[8'h40] = 8'h3C;
        pipe1 = 8'h00;
        for (int i = 0; i < 3; i++) pipe3[i] = 8'h00;

        // 1: reset with both requests high
        tick();
        if_req = 1'b1; if_addr = 8'h10;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 8'h20;
        for (int i = 0; i < 2; i++) begin
            mid();
            chk("rst_ram_we", ram_we, 1'b0);
            chk("rst_if_ack", if_ack, 1'b0);
            chk("rst_d_ack", d_ack, 1'b0);
            chk("rst_ram_addr", ram_addr, 8'h00);
            chk("rst_if_stall", if_stall, 1'b1);
            chk("rst_if_rdata", if_rdata, 8'h00);
            tick();
        end
        rst = 1'b0; if_req = 1'b0;
        mid();
        chk("post_rst_grant_addr", ram_addr, 8'h20);
        chk("post_rst_d_stall", d_stall, 1'b1);
        tick();
        mid();
        chk("post_rst_d_ack", d_ack, 1'b1);
        chk("post_rst_d_rdata", d_rdata, 8'h77);
        tick();
        d_req = 1'b0;
        mid();
        chk("idle_d_ack", d_ack, 1'b0);
        chk("idle_d_rdata_hold", d_rdata, 8'h77);
        chk("idle_ram_addr", ram_addr, 8'h00);

        // 2: fetch only
        tick();
        if_req = 1'b1; if_addr = 8'h10;
        mid();
        chk("if_T_stall", if_stall, 1'b1);
        chk("if_T_ack", if_ack, 1'b0);
        chk("if_T_addr", ram_addr, 8'h10);
        tick();
        mid();
        chk("if_T1_ack", if_ack, 1'b1);
        chk("if_T1_rdata", if_rdata, 8'hC3);
        chk("if_T1_stall", if_stall, 1'b0);
        tick();
        if_req = 1'b0;
        mid();
        chk("if_ack_pulse", if_ack, 1'b0);
        chk("if_rdata_hold", if_rdata, 8'hC3);

        // 3: write then read back
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'hFF; d_wdata = 8'h5A;
        mid();
        chk("wr_T_we", ram_we, 1'b1);
        chk("wr_T_addr", ram_addr, 8'hFF);
        chk("wr_T_wdata", ram_wdata, 8'h5A);
        chk("wr_T_ack", d_ack, 1'b0);
        tick();
        mid();
        chk("wr_T1_we", ram_we, 1'b0);
        chk("wr_T1_ack", d_ack, 1'b1);
        chk("wr_T1_rdata_unch", d_rdata, 8'h77);
        tick();
        d_we = 1'b0;
        mid();
        chk("rd_T_we", ram_we, 1'b0);
        chk("rd_T_addr", ram_addr, 8'hFF);
        tick();
        mid();
        chk("rd_T1_ack", d_ack, 1'b1);
        chk("rd_T1_rdata", d_rdata, 8'h5A);
        tick();
        d_req = 1'b0;

        // 4: both held continuously -> D,D,IF,...
        if_req = 1'b1; if_addr = 8'h10;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 8'h20;
        for (int k = 0; k < 9; k++) begin
            mid();
            chk($sformatf("arb_addr_%0d", k), ram_addr, (k % 3 == 2) ? 8'h10 : 8'h20);
            tick();
            mid();
            chk($sformatf("arb_if_ack_%0d", k), if_ack, (k % 3 == 2) ? 1'b1 : 1'b0);
            chk($sformatf("arb_d_ack_%0d", k), d_ack, (k % 3 == 2) ? 1'b0 : 1'b1);
            if (k % 3 == 2) chk($sformatf("arb_if_rdata_%0d", k), if_rdata, 8'hC3);
            else            chk($sformatf("arb_d_rdata_%0d", k), d_rdata, 8'h77);
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;

        // 5: RAM_LAT=3 with competing fetch
        d3_req = 1'b1; d3_we = 1'b0; d3_addr = 8'h30;
        if3_req = 1'b1; if3_addr = 8'h40;
        mid();
        chk("l3_T_addr", ram3_addr, 8'h30);
        for (int i = 1; i < 3; i++) begin
            tick();
            mid();
            chk($sformatf("l3_T%0d_d_ack", i), d3_ack, 1'b0);
            chk($sformatf("l3_T%0d_if_ack", i), if3_ack, 1'b0);
            chk($sformatf("l3_T%0d_addr", i), ram3_addr, 8'h30);
            chk($sformatf("l3_T%0d_if_stall", i), if3_stall, 1'b1);
        end
        tick();
        mid();
        chk("l3_T3_d_ack", d3_ack, 1'b1);
        chk("l3_T3_d_rdata", d3_rdata, 8'hA5);
        chk("l3_T3_if_ack", if3_ack, 1'b0);
        tick();
        d3_req = 1'b0;
        mid();
        chk("l3_T4_if_grant", ram3_addr, 8'h40);
        chk("l3_T4_if_ack", if3_ack, 1'b0);
        tick();
        tick();
        mid();
        chk("l3_T6_if_ack", if3_ack, 1'b0);
        tick();
        mid();
        chk("l3_T7_if_ack", if3_ack, 1'b1);
        chk("l3_T7_if_rdata", if3_rdata, 8'h3C);
        tick();
        if3_req = 1'b0;

        // 6: reset during a RAM_LAT=3 read
        d3_req = 1'b1; d3_we = 1'b0; d3_addr = 8'h30;
        mid();
        chk("rst3_T_addr", ram3_addr, 8'h30);
        tick();
        rst = 1'b1; d3_we = 1'b1; d3_wdata = 8'hEE;
        mid();
        chk("rst3_we_forced", ram3_we, 1'b0);
        chk("rst3_d_ack", d3_ack, 1'b0);
        tick();
        rst = 1'b0; d3_req = 1'b0; d3_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk($sformatf("rst3_no_ack_%0d", i), d3_ack, 1'b0);
            chk($sformatf("rst3_idle_addr_%0d", i), ram3_addr, 8'h00);
            tick();
        end
        if3_req = 1'b1; if3_addr = 8'h40;
        mid();
        chk("rst3_idle_grant", ram3_addr, 8'h40);
        tick();
        tick();
        tick();
        mid();
        chk("rst3_if_ack", if3_ack, 1'b1);
        chk("rst3_if_rdata", if3_rdata, 8'h3C);
        chk("rst3_mem_unwritten", mem3[8'h30], 8'hA5);
        tick();
        if3_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
